// File: rtl/alu_scheduler_pkg.sv
// alu_scheduler_pkg
//   Shared definitions for the ALU and its clients: command codes, flag bit
//   positions, and the scheduler state encoding.
//   No ports (package).
package alu_scheduler_pkg;

   // ALU command codes; every 3-bit value is a legal command.
   typedef enum logic [2:0] {
      CMD_ADD  = 3'd0,
      CMD_SUB  = 3'd1,
      CMD_XOR  = 3'd2,
      CMD_SLT  = 3'd3,
      CMD_AND  = 3'd4,
      CMD_NAND = 3'd5,
      CMD_NOR  = 3'd6,
      CMD_OR   = 3'd7
   } alu_cmd_e;

   // Bit positions inside the 3-bit {overflow, zero, carryout} flag vector.
   localparam int unsigned FLAG_OVF  = 2;
   localparam int unsigned FLAG_ZERO = 1;
   localparam int unsigned FLAG_COUT = 0;

   // Settle counter width; covers SETTLE_CYCLES up to 255.
   localparam int unsigned CNT_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RESP   = 2'd2
   } sched_state_e;

   // Assemble the flag vector in its documented bit order.
   function automatic logic [2:0] pack_flags(input logic ovf,
                                             input logic zero,
                                             input logic cout);
      logic [2:0] f;
      f            = '0;
      f[FLAG_OVF]  = ovf;
      f[FLAG_ZERO] = zero;
      f[FLAG_COUT] = cout;
      return f;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2
//   Combinational two-way round-robin grant. With a single requester valid
//   that requester wins; with both valid the one not served last wins.
//   Ports:
//     valid0_i, valid1_i  request valids
//     last_grant_i        requester served most recently
//     grant_o             index of the winning requester
//     grant_valid_o       at least one requester is valid
module rr_arb2 (
   input  logic valid0_i,
   input  logic valid1_i,
   input  logic last_grant_i,
   output logic grant_o,
   output logic grant_valid_o
);

   always_comb begin
      grant_valid_o = valid0_i | valid1_i;
      grant_o       = 1'b0;
      if (valid0_i && valid1_i) begin
         grant_o = ~last_grant_i;
      end else if (valid1_i) begin
         grant_o = 1'b1;
      end
   end

endmodule

// File: rtl/alu_scheduler.sv
// alu_scheduler
//   Time-shares one external 32-bit ALU between two requesters. A request is
//   accepted in IDLE (round-robin on ties), its operands are registered onto
//   the ALU inputs, the block waits SETTLE_CYCLES for the ripple logic to
//   settle, captures result and flags, and returns them on the owner's
//   response channel.
//   Ports:
//     clk, rst_n                     clock, async active-low reset
//     reqN_valid/_ready/_a/_b/_cmd   request channels (N = 0, 1)
//     respN_valid/_ready             response handshakes
//     resp_result, resp_flags        captured result / {ovf, zero, cout}
//     alu_a, alu_b, alu_cmd          registered operands to the ALU
//     alu_result, alu_carryout,
//     alu_zero, alu_overflow         ALU outputs
//     busy                           high in SETTLE or RESP
module alu_scheduler
   import alu_scheduler_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic [2:0]  req0_cmd,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic [2:0]  req1_cmd,
   output logic        resp0_valid,
   input  logic        resp0_ready,
   output logic        resp1_valid,
   input  logic        resp1_ready,
   output logic [31:0] resp_result,
   output logic [2:0]  resp_flags,
   output logic [31:0] alu_a,
   output logic [31:0] alu_b,
   output logic [2:0]  alu_cmd,
   input  logic [31:0] alu_result,
   input  logic        alu_carryout,
   input  logic        alu_zero,
   input  logic        alu_overflow,
   output logic        busy
);

   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYCLES - 1);

   sched_state_e     state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic             owner_q, owner_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [31:0]      a_q, a_d, b_q, b_d, res_q, res_d;
   logic [2:0]       cmd_q, cmd_d, flags_q, flags_d;

   logic grant, grant_valid, in_idle;

   rr_arb2 u_arb (
      .valid0_i      (req0_valid),
      .valid1_i      (req1_valid),
      .last_grant_i  (last_grant_q),
      .grant_o       (grant),
      .grant_valid_o (grant_valid)
   );

   // Gated with rst_n so ready cannot rise while reset is held.
   assign in_idle    = rst_n && (state_q == ST_IDLE);
   assign req0_ready = in_idle && grant_valid && !grant;
   assign req1_ready = in_idle && grant_valid && grant;

   assign resp0_valid = (state_q == ST_RESP) && !owner_q;
   assign resp1_valid = (state_q == ST_RESP) && owner_q;
   assign busy        = (state_q != ST_IDLE);

   assign alu_a       = a_q;
   assign alu_b       = b_q;
   assign alu_cmd     = cmd_q;
   assign resp_result = res_q;
   assign resp_flags  = flags_q;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      owner_d      = owner_q;
      cnt_d        = cnt_q;
      a_d          = a_q;
      b_d          = b_q;
      cmd_d        = cmd_q;
      res_d        = res_q;
      flags_d      = flags_q;
      case (state_q)
         ST_IDLE: begin
            // Ready is asserted exactly when a grant exists, so a grant is an accept.
            if (grant_valid) begin
               a_d          = grant ? req1_a   : req0_a;
               b_d          = grant ? req1_b   : req0_b;
               cmd_d        = grant ? req1_cmd : req0_cmd;
               last_grant_d = grant;
               owner_d      = grant;
               cnt_d        = CNT_LOAD;
               state_d      = ST_SETTLE;
            end
         end
         ST_SETTLE: begin
            if (cnt_q == '0) begin
               res_d   = alu_result;
               flags_d = pack_flags(alu_overflow, alu_zero, alu_carryout);
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            if (owner_q ? resp1_ready : resp0_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         last_grant_q <= 1'b1;
         owner_q      <= 1'b0;
         cnt_q        <= '0;
         a_q          <= '0;
         b_q          <= '0;
         cmd_q        <= '0;
         res_q        <= '0;
         flags_q      <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         owner_q      <= owner_d;
         cnt_q        <= cnt_d;
         a_q          <= a_d;
         b_q          <= b_d;
         cmd_q        <= cmd_d;
         res_q        <= res_d;
         flags_q      <= flags_d;
      end
   end

endmodule

// File: tb/tb_alu_scheduler.sv
// tb_alu_scheduler
//   Self-checking bench: a behavioural ALU sits on the alu_* port, a
//   scoreboard queues expected responses at each accept and compares them at
//   each response handshake.
module tb_alu_scheduler;
   import alu_scheduler_pkg::*;

   localparam int unsigned S = 4;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 1'b0, req1_valid = 1'b0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [2:0]  req0_cmd = '0, req1_cmd = '0;
   logic        resp0_valid, resp1_valid;
   logic        resp0_ready = 1'b1, resp1_ready = 1'b1;
   logic [31:0] resp_result;
   logic [2:0]  resp_flags;
   logic [31:0] alu_a, alu_b, alu_result;
   logic [2:0]  alu_cmd;
   logic        alu_carryout, alu_zero, alu_overflow;
   logic        busy;

   always #5 clk = ~clk;

   alu_scheduler #(.SETTLE_CYCLES(S)) dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_ready(req0_ready),
      .req0_a(req0_a), .req0_b(req0_b), .req0_cmd(req0_cmd),
      .req1_valid(req1_valid), .req1_ready(req1_ready),
      .req1_a(req1_a), .req1_b(req1_b), .req1_cmd(req1_cmd),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp_result(resp_result), .resp_flags(resp_flags),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cmd(alu_cmd),
      .alu_result(alu_result), .alu_carryout(alu_carryout),
      .alu_zero(alu_zero), .alu_overflow(alu_overflow),
      .busy(busy)
   );

   // Behavioural ALU: returns {ovf, zero, cout, result}.
   function automatic logic [34:0] alu_model(input logic [31:0] a,
                                             input logic [31:0] b,
                                             input logic [2:0]  cmd);
      logic [32:0] s;
      logic [31:0] r;
      logic        ovf, z, c;
      ovf = 1'b0; z = 1'b0; c = 1'b0; r = '0; s = '0;
      case (cmd)
         CMD_ADD: begin
            s = {1'b0, a} + {1'b0, b};
            r = s[31:0]; c = s[32];
            ovf = (a[31] == b[31]) && (r[31] != a[31]);
            z = (r == 32'd0);
         end
         CMD_SUB: begin
            s = {1'b0, a} + {1'b0, ~b} + 33'd1;
            r = s[31:0]; c = s[32];
            ovf = (a[31] != b[31]) && (r[31] != a[31]);
            z = (r == 32'd0);
         end
         CMD_XOR:  r = a ^ b;
         CMD_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         CMD_AND:  r = a & b;
         CMD_NAND: r = ~(a & b);
         CMD_NOR:  r = ~(a | b);
         CMD_OR:   r = a | b;
         default:  r = '0;
      endcase
      return {ovf, z, c, r};
   endfunction

   always_comb {alu_overflow, alu_zero, alu_carryout, alu_result} = alu_model(alu_a, alu_b, alu_cmd);

   int errors = 0;
   int checks = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   typedef struct packed {
      logic        owner;
      logic [34:0] fr;
   } exp_t;

   exp_t sbq[$];
   logic grant_log[$];
   int   cyc = 0;
   int   n_acc = 0;
   int   acc_edge [2];
   logic [1:0] seen = '0;
   logic [1:0] rv, rr;
   exp_t e;

   assign rv = {resp1_valid, resp0_valid};
   assign rr = {resp1_ready, resp0_ready};

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: sampled mid-cycle; a valid&&ready seen here is accepted at the next edge.
   always @(negedge clk) begin
      if (!rst_n) begin
         seen <= '0;
      end else begin
         if (req0_valid && req0_ready) begin
            sbq.push_back({1'b0, alu_model(req0_a, req0_b, req0_cmd)});
            grant_log.push_back(1'b0);
            acc_edge[0] <= cyc + 1;
            n_acc <= n_acc + 1;
         end
         if (req1_valid && req1_ready) begin
            sbq.push_back({1'b1, alu_model(req1_a, req1_b, req1_cmd)});
            grant_log.push_back(1'b1);
            acc_edge[1] <= cyc + 1;
            n_acc <= n_acc + 1;
         end
         check("both_ready", {31'd0, req0_ready & req1_ready}, 0);
         for (int n = 0; n < 2; n++) begin
            if (rv[n] && !seen[n]) check("resp_latency", cyc - acc_edge[n], S);
            if (rv[n] && rr[n]) begin
               check("other_resp_valid", rv[1-n], 0);
               check("sb_nonempty", sbq.size() != 0, 1);
               if (sbq.size() != 0) begin
                  e = sbq.pop_front();
                  check("resp_owner", n, e.owner);
                  check("resp_result", resp_result, e.fr[31:0]);
                  check("resp_flags", resp_flags, e.fr[34:32]);
               end
            end
         end
         seen <= rv;
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic drive(input int p, input logic v, input logic [31:0] a,
                        input logic [31:0] b, input logic [2:0] c);
      if (p == 0) begin
         req0_valid = v; req0_a = a; req0_b = b; req0_cmd = c;
      end else begin
         req1_valid = v; req1_a = a; req1_b = b; req1_cmd = c;
      end
   endtask

   task automatic wait_acc(input int target);
      for (int i = 0; i < 100 && n_acc < target; i++) @(negedge clk);
      check("accept_seen", n_acc >= target, 1);
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      @(negedge clk);
      while ((busy || sbq.size() != 0) && i < 200) begin
         @(negedge clk);
         i++;
      end
      check("drained", sbq.size(), 0);
   endtask

   task automatic do_op(input int p, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] c);
      int t;
      t = n_acc + 1;
      drive(p, 1'b1, a, b, c);
      wait_acc(t);
      tick();
      drive(p, 1'b0, '0, '0, '0);
      wait_idle();
   endtask

   logic [31:0] bp_exp;
   logic        any_resp;

   initial begin
      // Reset state, with both valids high so ready gating is exercised.
      drive(0, 1'b1, 32'h1, 32'h2, CMD_ADD);
      drive(1, 1'b1, 32'h3, 32'h4, CMD_ADD);
      repeat (3) tick();
      check("rst_ready0", req0_ready, 0);
      check("rst_ready1", req1_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_resp_valid", rv, 0);
      check("rst_alu_a", alu_a, 0);
      check("rst_alu_b", alu_b, 0);
      check("rst_alu_cmd", alu_cmd, 0);
      check("rst_result", resp_result, 0);
      check("rst_flags", resp_flags, 0);
      drive(0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, '0, '0, '0);
      rst_n = 1'b1;
      tick();

      // First op: signed overflow on ADD.
      do_op(0, 32'h7FFF_FFFF, 32'h0000_0001, CMD_ADD);
      // SUB 5-5: zero and carryout set.
      do_op(1, 32'd5, 32'd5, CMD_SUB);
      // SLT -3 < 2.
      do_op(0, 32'hFFFF_FFFD, 32'd2, CMD_SLT);
      // Every command code, alternating requesters.
      for (int unsigned k = 0; k < 8; k++)
         do_op(int'(k % 2), $urandom, $urandom, 3'(k));
      do_op(1, 32'h8000_0000, 32'h0000_0001, CMD_SUB);

      // Backpressure on resp0 while req1 waits.
      resp0_ready = 1'b0;
      drive(0, 1'b1, 32'h1234_5678, 32'h0F0F_0F0F, CMD_XOR);
      bp_exp = 32'h1234_5678 ^ 32'h0F0F_0F0F;
      wait_acc(n_acc + 1);
      tick();
      drive(0, 1'b0, '0, '0, '0);
      drive(1, 1'b1, 32'd9, 32'd1, CMD_ADD);
      for (int i = 0; i < 50 && !resp0_valid; i++) @(negedge clk);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_valid", resp0_valid, 1);
         check("bp_result", resp_result, bp_exp);
         check("bp_ready0", req0_ready, 0);
         check("bp_ready1", req1_ready, 0);
         check("bp_busy", busy, 1);
      end
      tick();
      resp0_ready = 1'b1;
      drive(1, 1'b0, '0, '0, '0);
      @(negedge clk);
      @(negedge clk);
      check("bp_idle_busy", busy, 0);
      check("bp_idle_valid", resp0_valid, 0);
      wait_idle();

      // Simultaneous requests from the first post-reset edge: 0, 1, 0.
      tick();
      rst_n = 1'b0;
      sbq.delete();
      grant_log.delete();
      drive(0, 1'b1, 32'd100, 32'd23, CMD_ADD);
      drive(1, 1'b1, 32'hF0F0_0000, 32'h0000_0F0F, CMD_OR);
      repeat (2) tick();
      rst_n = 1'b1;
      @(negedge clk);
      check("first_edge_grant0", req0_ready, 1);
      wait_acc(n_acc + 3);
      tick();
      drive(0, 1'b0, '0, '0, '0);
      drive(1, 1'b0, '0, '0, '0);
      wait_idle();
      check("grant_count", grant_log.size(), 3);
      if (grant_log.size() >= 3) begin
         check("grant_1st", grant_log[0], 0);
         check("grant_2nd", grant_log[1], 1);
         check("grant_3rd", grant_log[2], 0);
      end

      // Reset in the second SETTLE cycle aborts the op.
      drive(0, 1'b1, 32'hDEAD_BEEF, 32'h1, CMD_ADD);
      wait_acc(n_acc + 1);
      @(posedge clk); #1;
      rst_n = 1'b0;
      drive(0, 1'b0, '0, '0, '0);
      #1;
      check("abort_busy", busy, 0);
      check("abort_alu_a", alu_a, 0);
      check("abort_resp_valid", rv, 0);
      check("abort_result", resp_result, 0);
      sbq.delete();
      repeat (2) tick();
      rst_n = 1'b1;
      any_resp = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         any_resp = any_resp | resp0_valid | resp1_valid;
      end
      check("abort_no_resp", any_resp, 0);
      tick();
      do_op(0, 32'd40, 32'd2, CMD_ADD);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
      $fatal(1);
   end

endmodule
